prod_sched: RTL and testbench

//  Shares the buffer write port (data_1/data_1_en of the CDC wrapper) between the fibonacci and timer generators.

---
 rtl/prod_sched_pkg.sv | 39 +++
 rtl/prod_sched_rr_arb2.sv | 33 +++
 rtl/prod_sched.sv | 187 ++++++++++++++++++
 tb/tb_prod_sched.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/prod_sched_pkg.sv
// Shared definitions for the producer scheduler: FSM state encoding,
// source identifiers, LED bit positions and the modules select codes.
package prod_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  typedef enum logic {
    SRC_F = 1'b0,
    SRC_T = 1'b1
  } src_t;

  localparam int LED_RUN   = 0;
  localparam int LED_HOLD  = 1;
  localparam int LED_DRAIN = 2;
  localparam int LED_FIB   = 3;
  localparam int LED_TMR   = 4;
  localparam int LED_ILL   = 5;

  localparam logic [1:0] MOD_NONE = 2'd0;
  localparam logic [1:0] MOD_FIB  = 2'd1;
  localparam logic [1:0] MOD_TMR  = 2'd2;
  localparam logic [1:0] MOD_BOTH = 2'd3;

  // Display select code from the two active flags.
  function automatic logic [1:0] mod_code(input logic fib_act, input logic tmr_act);
    case ({tmr_act, fib_act})
      2'b01:   return MOD_FIB;
      2'b10:   return MOD_TMR;
      2'b11:   return MOD_BOTH;
      default: return MOD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/prod_sched_rr_arb2.sv
// Two-way round-robin arbiter. A lone request is granted directly; when both
// request, the pointer decides. After any advancing grant the pointer moves
// to the source that was not granted.
module rr_arb2
  import prod_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  src_t ptr;

  // Grant selection: pointer only matters on a tie.
  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = (ptr == SRC_F) ? 2'b01 : 2'b10;
    end
  end

  // Pointer flips away from whichever source was just served.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= SRC_F;
    end else if (advance && (grant != 2'b00)) begin
      ptr <= grant[0] ? SRC_T : SRC_F;
    end
  end

endmodule

// File: rtl/prod_sched.sv
// Producer scheduler: shares the buffer write port between the fibonacci and
// timer generators through 1-entry hold registers and a round-robin arbiter,
// and sequences run / full-pause / drain.
// Optional build macro PROD_SCHED_STATS_EN adds per-source write counters
// f_count / t_count (16-bit, wrapping, cleared by rst).
//
// state | meaning
// IDLE  | no source active, waiting for a start pulse
// RUN   | generators enabled while their hold is empty, holds drained
// HOLD  | buffer full: generators paused, no writes
// DRAIN | stopped: remaining holds written, wait for buffer and reader idle
module prod_sched
  import prod_sched_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_f,
  input  logic              start_t,
  input  logic              stop,
  input  logic              f_valid,
  input  logic [DATA_W-1:0] f_data,
  input  logic              t_valid,
  input  logic [DATA_W-1:0] t_data,
  input  logic              buffer_full,
  input  logic              buffer_empty,
  input  logic              rd_busy,
  output logic              f_en,
  output logic              t_en,
  output logic              wr_en,
  output logic [DATA_W-1:0] wr_data,
  output logic [1:0]        modules,
  output logic [5:0]        led
`ifdef PROD_SCHED_STATS_EN
  ,
  output logic [15:0]       f_count,
  output logic [15:0]       t_count
`endif
);

  state_t            state, state_n;
  logic              active_f, active_t, act_f_n, act_t_n;
  logic              ill_seen, ill_n;
  logic              start_f_q, start_t_q, stop_q;
  logic              sf_p, st_p, stop_p;
  logic              hold_f_full, hold_t_full;
  logic [DATA_W-1:0] hold_f, hold_t;
  logic              wr_ok;
  logic [1:0]        req, grant;

  assign sf_p   = start_f & ~start_f_q;
  assign st_p   = start_t & ~start_t_q;
  assign stop_p = stop & ~stop_q;

  assign f_en  = active_f & ~hold_f_full & (state == ST_RUN);
  assign t_en  = active_t & ~hold_t_full & (state == ST_RUN);
  assign wr_ok = ((state == ST_RUN) || (state == ST_DRAIN)) & ~buffer_full;
  assign req   = {hold_t_full, hold_f_full} & {2{wr_ok}};

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .advance (wr_ok),
    .grant   (grant)
  );

  // Next-state and active-source bookkeeping.
  always_comb begin
    state_n = state;
    act_f_n = active_f;
    act_t_n = active_t;
    ill_n   = ill_seen;
    case (state)
      ST_IDLE: begin
        if (sf_p || st_p) begin
          act_f_n = active_f | sf_p;
          act_t_n = active_t | st_p;
          state_n = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop_p) begin
          state_n = ST_DRAIN;
        end else begin
          act_f_n = active_f | sf_p;
          act_t_n = active_t | st_p;
          if (buffer_full) state_n = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (stop_p)            state_n = ST_DRAIN;
        else if (!buffer_full) state_n = ST_RUN;
      end
      ST_DRAIN: begin
        if (!hold_f_full && !hold_t_full && buffer_empty && !rd_busy) begin
          state_n = ST_IDLE;
          act_f_n = 1'b0;
          act_t_n = 1'b0;
        end
      end
      default: begin
        state_n = ST_IDLE;
        ill_n   = 1'b1;
      end
    endcase
  end

  // Control registers and pulse edge detectors.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      active_f  <= 1'b0;
      active_t  <= 1'b0;
      ill_seen  <= 1'b0;
      start_f_q <= 1'b0;
      start_t_q <= 1'b0;
      stop_q    <= 1'b0;
    end else begin
      state     <= state_n;
      active_f  <= act_f_n;
      active_t  <= act_t_n;
      ill_seen  <= ill_n;
      start_f_q <= start_f;
      start_t_q <= start_t;
      stop_q    <= stop;
    end
  end

  // Hold capture and write port. A full hold never captures, so grant-clear
  // and capture of the same hold cannot coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_f_full <= 1'b0;
      hold_t_full <= 1'b0;
      hold_f      <= '0;
      hold_t      <= '0;
      wr_en       <= 1'b0;
      wr_data     <= '0;
    end else begin
      wr_en <= |grant;
      if (grant[0])      wr_data <= hold_f;
      else if (grant[1]) wr_data <= hold_t;

      if (grant[0]) begin
        hold_f_full <= 1'b0;
      end else if (f_valid && f_en) begin
        hold_f      <= f_data;
        hold_f_full <= 1'b1;
      end

      if (grant[1]) begin
        hold_t_full <= 1'b0;
      end else if (t_valid && t_en) begin
        hold_t      <= t_data;
        hold_t_full <= 1'b1;
      end
    end
  end

  // Status outputs decoded from the registered state.
  always_comb begin
    modules            = mod_code(active_f, active_t);
    led                = '0;
    led[LED_RUN]       = (state == ST_RUN);
    led[LED_HOLD]      = (state == ST_HOLD);
    led[LED_DRAIN]     = (state == ST_DRAIN);
    led[LED_FIB]       = active_f;
    led[LED_TMR]       = active_t;
    led[LED_ILL]       = ill_seen;
  end

`ifdef PROD_SCHED_STATS_EN
  // Per-source write counters, advanced with the write strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      f_count <= '0;
      t_count <= '0;
    end else begin
      if (grant[0]) f_count <= f_count + 16'd1;
      if (grant[1]) t_count <= t_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_prod_sched.sv
// Bench for prod_sched: directed cycle table, randomized run against a
// queue-based reference model, and a mid-run reset sequence.
module tb_prod_sched;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start_f = 1'b0, start_t = 1'b0, stop = 1'b0;
  logic         f_valid = 1'b0, t_valid = 1'b0;
  logic [W-1:0] f_data = '0, t_data = '0;
  logic         buffer_full = 1'b0, buffer_empty = 1'b0, rd_busy = 1'b0;
  logic         f_en, t_en, wr_en;
  logic [W-1:0] wr_data;
  logic [1:0]   modules;
  logic [5:0]   led;
`ifdef PROD_SCHED_STATS_EN
  logic [15:0]  f_count, t_count;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  prod_sched #(.DATA_W(W)) dut (
    .clk(clk), .rst(rst), .start_f(start_f), .start_t(start_t), .stop(stop),
    .f_valid(f_valid), .f_data(f_data), .t_valid(t_valid), .t_data(t_data),
    .buffer_full(buffer_full), .buffer_empty(buffer_empty), .rd_busy(rd_busy),
    .f_en(f_en), .t_en(t_en), .wr_en(wr_en), .wr_data(wr_data),
    .modules(modules), .led(led)
`ifdef PROD_SCHED_STATS_EN
    , .f_count(f_count), .t_count(t_count)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic sf, stt, sp, fv; logic [15:0] fd; logic tv; logic [15:0] td;
    logic bf, be, rd;
    logic e_fen, e_ten, e_wr; logic [15:0] e_wd; logic [1:0] e_mod; logic [5:0] e_led;
  } vec_t;

  vec_t tbl [16];

  task automatic apply_vec(input vec_t v);
    start_f = v.sf; start_t = v.stt; stop = v.sp;
    f_valid = v.fv; f_data = v.fd; t_valid = v.tv; t_data = v.td;
    buffer_full = v.bf; buffer_empty = v.be; rd_busy = v.rd;
  endtask

  task automatic clear_inputs();
    start_f = 0; start_t = 0; stop = 0; f_valid = 0; t_valid = 0;
    f_data = '0; t_data = '0; buffer_full = 0; buffer_empty = 0; rd_busy = 0;
  endtask

  // ---------------- reference model ----------------
  // States: 0 idle, 1 run, 2 hold, 3 drain. Hold contents as per-source queues.
  int           m_st;
  bit           m_af, m_at, m_last_t, m_wr;
  logic [15:0]  m_wd;
  logic [15:0]  qf[$], qt[$];
  bit           p_sf, p_st, p_sp;
  int           m_fcnt, m_tcnt;

  task automatic model_reset();
    m_st = 0; m_af = 0; m_at = 0; m_last_t = 1; m_wr = 0; m_wd = '0;
    qf.delete(); qt.delete(); p_sf = 0; p_st = 0; p_sp = 0;
    m_fcnt = 0; m_tcnt = 0;
  endtask

  task automatic model_step();
    bit sfp, stp, spp, fen, ten, empty, pick_t;
    logic [5:0] eled;
    fen = m_af && (qf.size() == 0) && (m_st == 1);
    ten = m_at && (qt.size() == 0) && (m_st == 1);
    eled = {1'b0, m_at, m_af, m_st == 3, m_st == 2, m_st == 1};
    chk("rnd f_en", f_en, fen);
    chk("rnd t_en", t_en, ten);
    chk("rnd modules", modules, {m_at, m_af});
    chk("rnd led", led, eled);
    chk("rnd wr_en", wr_en, m_wr);
    if (m_wr) chk("rnd wr_data", wr_data, m_wd);

    sfp = start_f && !p_sf; stp = start_t && !p_st; spp = stop && !p_sp;
    p_sf = start_f; p_st = start_t; p_sp = stop;
    empty = (qf.size() == 0) && (qt.size() == 0);

    m_wr = 0;
    if ((m_st == 1 || m_st == 3) && !buffer_full && !empty) begin
      if (qf.size() != 0 && qt.size() != 0) pick_t = !m_last_t;
      else pick_t = (qt.size() != 0);
      m_wr = 1;
      m_last_t = pick_t;
      if (pick_t) begin m_wd = qt.pop_front(); m_tcnt++; end
      else        begin m_wd = qf.pop_front(); m_fcnt++; end
    end
    if (f_valid && fen) qf.push_back(f_data);
    if (t_valid && ten) qt.push_back(t_data);

    case (m_st)
      0: if (sfp || stp) begin m_af = sfp; m_at = stp; m_st = 1; end
      1: if (spp) m_st = 3;
         else begin
           m_af = m_af | sfp; m_at = m_at | stp;
           if (buffer_full) m_st = 2;
         end
      2: if (spp) m_st = 3; else if (!buffer_full) m_st = 1;
      default: if (empty && buffer_empty && !rd_busy) begin m_st = 0; m_af = 0; m_at = 0; end
    endcase
  endtask

  initial begin
    int bf_left;
    //            sf  st  sp  fv  fd        tv  td        bf  be  rd   fen ten wr  wd        mod    led
    tbl[0]  = '{'1, '0, '0, '0, 16'h0000, '0, 16'h0000, '0, '0, '0,  '0, '0, '0, 16'h0000, 2'd0, 6'b000000};
    tbl[1]  = '{'0, '0, '0, '1, 16'h0001, '0, 16'h0000, '0, '0, '0,  '1, '0, '0, 16'h0000, 2'd1, 6'b001001};
    tbl[2]  = '{'0, '0, '0, '1, 16'h0099, '0, 16'h0000, '0, '0, '0,  '0, '0, '0, 16'h0000, 2'd1, 6'b001001};
    tbl[3]  = '{'0, '0, '0, '1, 16'h0001, '0, 16'h0000, '0, '0, '0,  '1, '0, '1, 16'h0001, 2'd1, 6'b001001};
    tbl[4]  = '{'0, '0, '0, '0, 16'h0000, '0, 16'h0000, '0, '0, '0,  '0, '0, '0, 16'h0000, 2'd1, 6'b001001};
    tbl[5]  = '{'0, '1, '0, '1, 16'h0002, '0, 16'h0000, '0, '0, '0,  '1, '0, '1, 16'h0001, 2'd1, 6'b001001};
    tbl[6]  = '{'0, '0, '0, '0, 16'h0000, '1, 16'h0B00, '0, '0, '0,  '0, '1, '0, 16'h0000, 2'd3, 6'b011001};
    tbl[7]  = '{'0, '0, '0, '1, 16'h0003, '0, 16'h0000, '0, '0, '0,  '1, '0, '1, 16'h0002, 2'd3, 6'b011001};
    tbl[8]  = '{'0, '0, '0, '0, 16'h0000, '1, 16'h0B01, '1, '0, '0,  '0, '1, '1, 16'h0B00, 2'd3, 6'b011001};
    tbl[9]  = '{'0, '0, '0, '0, 16'h0000, '0, 16'h0000, '1, '0, '0,  '0, '0, '0, 16'h0000, 2'd3, 6'b011010};
    tbl[10] = '{'0, '0, '1, '0, 16'h0000, '0, 16'h0000, '0, '0, '0,  '0, '0, '0, 16'h0000, 2'd3, 6'b011010};
    tbl[11] = '{'0, '0, '0, '0, 16'h0000, '0, 16'h0000, '0, '0, '1,  '0, '0, '0, 16'h0000, 2'd3, 6'b011100};
    tbl[12] = '{'0, '0, '0, '0, 16'h0000, '0, 16'h0000, '0, '0, '1,  '0, '0, '1, 16'h0003, 2'd3, 6'b011100};
    tbl[13] = '{'0, '0, '0, '0, 16'h0000, '0, 16'h0000, '0, '1, '1,  '0, '0, '1, 16'h0B01, 2'd3, 6'b011100};
    tbl[14] = '{'0, '0, '0, '0, 16'h0000, '0, 16'h0000, '0, '1, '0,  '0, '0, '0, 16'h0000, 2'd3, 6'b011100};
    tbl[15] = '{'0, '0, '0, '0, 16'h0000, '0, 16'h0000, '0, '0, '0,  '0, '0, '0, 16'h0000, 2'd0, 6'b000000};

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("reset f_en", f_en, 0);
    chk("reset t_en", t_en, 0);
    chk("reset wr_en", wr_en, 0);
    chk("reset wr_data", wr_data, 0);
    chk("reset modules", modules, 0);
    chk("reset led", led, 0);

    // Directed table
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      apply_vec(tbl[i]);
      @(negedge clk);
      chk($sformatf("tbl[%0d] f_en", i), f_en, tbl[i].e_fen);
      chk($sformatf("tbl[%0d] t_en", i), t_en, tbl[i].e_ten);
      chk($sformatf("tbl[%0d] wr_en", i), wr_en, tbl[i].e_wr);
      if (tbl[i].e_wr) chk($sformatf("tbl[%0d] wr_data", i), wr_data, tbl[i].e_wd);
      chk($sformatf("tbl[%0d] modules", i), modules, tbl[i].e_mod);
      chk($sformatf("tbl[%0d] led", i), led, tbl[i].e_led);
    end

    // Randomized run against the model
    @(posedge clk); #1;
    clear_inputs(); rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    model_reset();
    bf_left = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      start_f = ($urandom_range(0, 24) == 0);
      start_t = ($urandom_range(0, 24) == 0);
      stop    = ($urandom_range(0, 59) == 0);
      f_valid = ($urandom_range(0, 1) == 1);
      t_valid = ($urandom_range(0, 1) == 1);
      f_data  = 16'($urandom);
      t_data  = 16'($urandom);
      if (bf_left > 0) begin
        buffer_full = 1; bf_left--;
      end else begin
        buffer_full = 0;
        if ($urandom_range(0, 15) == 0) bf_left = $urandom_range(1, 12);
      end
      buffer_empty = ($urandom_range(0, 2) != 0);
      rd_busy      = ($urandom_range(0, 2) == 0);
      @(negedge clk);
      model_step();
    end
`ifdef PROD_SCHED_STATS_EN
    chk("rnd f_count", f_count, 16'(m_fcnt));
    chk("rnd t_count", t_count, 16'(m_tcnt));
`endif

    // Reset mid-RUN with both holds full
    @(posedge clk); #1;
    clear_inputs(); rst = 1;
    @(posedge clk); #1;
    rst = 0; start_f = 1; start_t = 1;
    @(posedge clk); #1;
    start_f = 0; start_t = 0; f_valid = 1; t_valid = 1; f_data = 16'h00A0; t_data = 16'h0B00;
    @(negedge clk);
    chk("rst5 modules before", modules, 3);
    chk("rst5 f_en before", f_en, 1);
    @(posedge clk); #1;
    f_valid = 0; t_valid = 0; rst = 1;
    @(negedge clk);
    chk("rst5 holds full f_en", f_en, 0);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("rst5 f_en", f_en, 0);
    chk("rst5 t_en", t_en, 0);
    chk("rst5 wr_en", wr_en, 0);
    chk("rst5 wr_data", wr_data, 0);
    chk("rst5 modules", modules, 0);
    chk("rst5 led", led, 0);
`ifdef PROD_SCHED_STATS_EN
    chk("rst5 f_count", f_count, 0);
`endif
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      f_valid = 1; t_valid = 1; buffer_empty = 1;
      @(negedge clk);
      chk($sformatf("rst5 idle wr_en[%0d]", k), wr_en, 0);
      chk($sformatf("rst5 idle f_en[%0d]", k), f_en, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
